// File: rtl/nanb_pkg.sv
// Shared types and helpers for the nAnB game controller.
// Holds the state encoding, the 7-seg display codes and the switch-to-digit decode.
package nanb_pkg;

   typedef enum logic [2:0] {StSet, StGuess, StCmp, StShow, StWin, StLose} state_t;

   localparam logic [3:0] CODE_A     = 4'hA;
   localparam logic [3:0] CODE_B     = 4'hB;
   localparam logic [3:0] CODE_BLANK = 4'hF;

   typedef struct packed {
      logic       valid;
      logic [3:0] bcd;
   } digit_t;

   // valid only when exactly one switch is high
   function automatic digit_t onehot10_to_bcd(input logic [9:0] sw);
      digit_t r;
      r = '0;
      for (int k = 0; k < 10; k++) begin
         if (sw == (10'd1 << k)) begin
            r.valid = 1'b1;
            r.bcd   = 4'(k);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/nanb_score.sv
// Sequential bulls/cows scorer: one guess position per cycle, HEX3 position first.
// done pulses on the 4th edge after start; a_cnt/b_cnt hold until the next start.
module nanb_score import nanb_pkg::*; (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] secret,
   input  logic [15:0] guess,
   output logic [2:0]  a_cnt,
   output logic [2:0]  b_cnt,
   output logic        done
);

   logic [1:0] pos, cur_pos;
   logic       busy, hit, present;
   logic [3:0] g_dig;
   logic [2:0] a_base, b_base;

   always_comb begin
      cur_pos = start ? 2'd3 : pos;
      g_dig   = guess[4*cur_pos +: 4];
      hit     = (g_dig == secret[4*cur_pos +: 4]);
      present = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (g_dig == secret[4*k +: 4]) present = 1'b1;
      end
      a_base = start ? 3'd0 : a_cnt;
      b_base = start ? 3'd0 : b_cnt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos   <= 2'd0;
         busy  <= 1'b0;
         a_cnt <= 3'd0;
         b_cnt <= 3'd0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start || busy) begin
            a_cnt <= a_base + {2'b00, hit};
            b_cnt <= b_base + {2'b00, ~hit & present};
            if (cur_pos == 2'd0) begin
               busy <= 1'b0;
               done <= 1'b1;
            end else begin
               busy <= 1'b1;
               pos  <= cur_pos - 2'd1;
            end
         end
      end
   end

endmodule

// File: rtl/nanb_game_ctrl.sv
// nAnB game sequencer: secret/guess entry, attempt counting, scoring and display mux.
// Display and LED outputs are registered one cycle behind the game state.
module nanb_game_ctrl import nanb_pkg::*; #(
   parameter int unsigned MAX_TRY   = 9,
   parameter int unsigned BLINK_DIV = 25_000_000
) (
   input  logic        iClk,
   input  logic        iRst_n,
   input  logic        iBtn,
   input  logic [9:0]  iSwitch,
   output logic [23:0] oDigit,
   output logic [4:0]  oLED,
   output logic        oErr
);

   localparam int unsigned CntW    = $clog2(BLINK_DIV + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(BLINK_DIV - 1);
   localparam logic [3:0] MaxTry   = 4'(MAX_TRY);

   state_t          state;
   logic            btn_d, press, dup, digit_ok, score_start, score_done, blink_off, err;
   logic [15:0]     secret, guess, word;
   logic [1:0]      idx;
   logic [3:0]      try_cnt;
   logic [2:0]      a_cnt, b_cnt, sc_a, sc_b;
   logic [CntW-1:0] blink_cnt;
   logic [23:0]     disp_d;
   logic [4:0]      led_d;
   digit_t          sw_dig;

   assign press  = iBtn & ~btn_d;
   assign sw_dig = onehot10_to_bcd(iSwitch);
   assign oErr   = err;

   nanb_score u_score (
      .clk    (iClk),
      .rst_n  (iRst_n),
      .start  (score_start),
      .secret (secret),
      .guess  (guess),
      .a_cnt  (sc_a),
      .b_cnt  (sc_b),
      .done   (score_done)
   );

   // duplicate check covers only the positions already entered in this word
   always_comb begin
      word = (state == StSet) ? secret : guess;
      dup  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k < int'(idx) && word[15-4*k -: 4] == sw_dig.bcd) dup = 1'b1;
      end
      digit_ok = sw_dig.valid & ~dup;
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state       <= StSet;
         btn_d       <= 1'b0;
         secret      <= '0;
         guess       <= '0;
         idx         <= '0;
         try_cnt     <= '0;
         a_cnt       <= '0;
         b_cnt       <= '0;
         err         <= 1'b0;
         score_start <= 1'b0;
         blink_cnt   <= '0;
         blink_off   <= 1'b0;
      end else begin
         btn_d       <= iBtn;
         score_start <= 1'b0;
         case (state)
            StSet, StGuess: begin
               if (press) begin
                  if (!digit_ok) begin
                     err <= 1'b1;
                  end else begin
                     err <= 1'b0;
                     if (state == StSet) secret[4*(3-int'(idx)) +: 4] <= sw_dig.bcd;
                     else                guess[4*(3-int'(idx)) +: 4]  <= sw_dig.bcd;
                     if (idx == 2'd3) begin
                        idx <= '0;
                        if (state == StSet) begin
                           state <= StGuess;
                        end else begin
                           try_cnt     <= try_cnt + 4'd1;
                           score_start <= 1'b1;
                           state       <= StCmp;
                        end
                     end else begin
                        idx <= idx + 2'd1;
                     end
                  end
               end
            end
            StCmp: begin
               if (score_done) begin
                  a_cnt     <= sc_a;
                  b_cnt     <= sc_b;
                  blink_cnt <= '0;
                  blink_off <= 1'b0;
                  if (sc_a == 3'd4)          state <= StWin;
                  else if (try_cnt == MaxTry) state <= StLose;
                  else                        state <= StShow;
               end
            end
            StShow: begin
               if (press) begin
                  guess <= '0;
                  a_cnt <= '0;
                  b_cnt <= '0;
                  idx   <= '0;
                  err   <= 1'b0;
                  state <= StGuess;
               end
            end
            StWin, StLose: begin
               if (press) begin
                  state     <= StSet;
                  secret    <= '0;
                  guess     <= '0;
                  idx       <= '0;
                  try_cnt   <= '0;
                  a_cnt     <= '0;
                  b_cnt     <= '0;
                  err       <= 1'b0;
                  blink_cnt <= '0;
                  blink_off <= 1'b0;
               end else if (blink_cnt == LastCnt) begin
                  blink_cnt <= '0;
                  blink_off <= ~blink_off;
               end else begin
                  blink_cnt <= blink_cnt + CntW'(1);
               end
            end
            default: state <= StSet;
         endcase
      end
   end

   always_comb begin
      disp_d = {6{CODE_BLANK}};
      led_d  = 5'b00001;
      case (state)
         StSet: begin
            for (int k = 0; k < 4; k++) begin
               if (k < int'(idx)) disp_d[15-4*k -: 4] = secret[15-4*k -: 4];
            end
         end
         StGuess, StCmp: begin
            led_d          = 5'b00010;
            disp_d[23:20]  = try_cnt;
            for (int k = 0; k < 4; k++) begin
               if (state == StCmp || k < int'(idx)) disp_d[15-4*k -: 4] = guess[15-4*k -: 4];
            end
         end
         StShow: begin
            led_d          = 5'b00100;
            disp_d[23:20]  = try_cnt;
            disp_d[15:0]   = {1'b0, a_cnt, CODE_A, 1'b0, b_cnt, CODE_B};
         end
         StWin: begin
            led_d          = 5'b01000;
            disp_d[23:20]  = try_cnt;
            if (!blink_off) disp_d[15:0] = {4'd4, CODE_A, 4'd0, CODE_B};
         end
         StLose: begin
            led_d          = 5'b10000;
            disp_d[23:20]  = try_cnt;
            if (!blink_off) disp_d[15:0] = secret;
         end
         default: ;
      endcase
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         oDigit <= {6{CODE_BLANK}};
         oLED   <= 5'b00001;
      end else begin
         oDigit <= disp_d;
         oLED   <= led_d;
      end
   end

endmodule

// File: tb/tb_nanb_game_ctrl.sv
// Self-checking bench for nanb_game_ctrl: directed scenarios plus randomized games
// scored by a simple all-pairs bulls/cows reference.
module tb_nanb_game_ctrl;

   localparam int unsigned MaxTry   = 2;
   localparam int unsigned BlinkDiv = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        btn = 1'b0;
   logic [9:0]  sw = '0;
   logic [23:0] digit;
   logic [4:0]  led;
   logic        err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nanb_game_ctrl #(.MAX_TRY(MaxTry), .BLINK_DIV(BlinkDiv)) dut (
      .iClk    (clk),
      .iRst_n  (rst_n),
      .iBtn    (btn),
      .iSwitch (sw),
      .oDigit  (digit),
      .oLED    (led),
      .oErr    (err)
   );

   function automatic logic [9:0] oh(input int d);
      logic [9:0] v;
      v = 10'd1 << d;
      return v;
   endfunction

   // A = same digit same place, B = same digit other place
   function automatic logic [7:0] ref_ab(input logic [15:0] s, input logic [15:0] g);
      int a = 0;
      int b = 0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (g[4*i +: 4] == s[4*j +: 4]) begin
               if (i == j) a++;
               else b++;
            end
      return {4'(a), 4'(b)};
   endfunction

   function automatic logic [15:0] rand_word();
      int p[10];
      int j, t;
      for (int i = 0; i < 10; i++) p[i] = i;
      for (int i = 9; i > 0; i--) begin
         j = $urandom_range(i, 0);
         t = p[i]; p[i] = p[j]; p[j] = t;
      end
      return {4'(p[0]), 4'(p[1]), 4'(p[2]), 4'(p[3])};
   endfunction

   task automatic press(input logic [9:0] s);
      @(negedge clk); sw = s; btn = 1'b1;
      @(negedge clk); btn = 1'b0;
      @(negedge clk);
   endtask

   task automatic enter_word(input logic [15:0] w);
      for (int i = 3; i >= 0; i--) press(oh(int'(w[4*i +: 4])));
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   task automatic wait_result();
      bit ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (led inside {5'b00100, 5'b01000, 5'b10000}) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL wait_result: led=%b never reached a result state", led); end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks += 3;
      if (digit !== 24'hFFFFFF) begin errors++; $display("FAIL reset_digit: got %h want ffffff", digit); end
      if (led !== 5'b00001) begin errors++; $display("FAIL reset_led: got %b want 00001", led); end
      if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
      rst_n = 1'b1;
      press(oh(3)); press(oh(4));
      checks++;
      if (digit !== 24'hFF34FF) begin errors++; $display("FAIL set_partial: got %h want ff34ff", digit); end
      press(10'b11);
      @(negedge clk); #2 rst_n = 1'b0;
      #1;
      checks += 3;
      if (digit !== 24'hFFFFFF) begin errors++; $display("FAIL async_rst_digit: got %h want ffffff", digit); end
      if (led !== 5'b00001) begin errors++; $display("FAIL async_rst_led: got %b want 00001", led); end
      if (err !== 1'b0) begin errors++; $display("FAIL async_rst_err: got %b want 0", err); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_show();
      press(oh(1)); press(oh(2));
      checks++;
      if (digit !== 24'hFF12FF) begin errors++; $display("FAIL show_set2: got %h want ff12ff", digit); end
      press(oh(3)); press(oh(4));
      checks += 2;
      if (led !== 5'b00010) begin errors++; $display("FAIL show_guess_led: got %b want 00010", led); end
      if (digit !== 24'h0FFFFF) begin errors++; $display("FAIL show_guess_digit: got %h want 0fffff", digit); end
      press(oh(1)); press(oh(3)); press(oh(2)); press(oh(5));
      repeat (4) @(negedge clk);
      checks++;
      if (led !== 5'b00010) begin errors++; $display("FAIL cmp_early: got %b want 00010", led); end
      @(negedge clk);
      checks += 2;
      if (led !== 5'b00100) begin errors++; $display("FAIL cmp_latency: got %b want 00100", led); end
      if (digit !== 24'h1F1A2B) begin errors++; $display("FAIL show_digit: got %h want 1f1a2b", digit); end
   endtask

   task automatic test_win();
      press(10'b0);
      checks += 2;
      if (led !== 5'b00010) begin errors++; $display("FAIL show_to_guess_led: got %b want 00010", led); end
      if (digit !== 24'h1FFFFF) begin errors++; $display("FAIL show_to_guess_digit: got %h want 1fffff", digit); end
      enter_word(16'h1234);
      wait_result();
      checks += 2;
      if (led !== 5'b01000) begin errors++; $display("FAIL win_led: got %b want 01000", led); end
      if (digit !== 24'h2F4A0B) begin errors++; $display("FAIL win_digit: got %h want 2f4a0b", digit); end
      repeat (6) @(negedge clk);
      checks++;
      if (digit !== 24'h2F4A0B) begin errors++; $display("FAIL win_before_blink: got %h want 2f4a0b", digit); end
      repeat (4) @(negedge clk);
      checks++;
      if (digit !== 24'h2FFFFF) begin errors++; $display("FAIL win_blank: got %h want 2fffff", digit); end
      repeat (7) @(negedge clk);
      checks++;
      if (digit !== 24'h2F4A0B) begin errors++; $display("FAIL win_unblank: got %h want 2f4a0b", digit); end
      press(oh(7));
      checks += 3;
      if (led !== 5'b00001) begin errors++; $display("FAIL win_to_set_led: got %b want 00001", led); end
      if (digit !== 24'hFFFFFF) begin errors++; $display("FAIL win_to_set_digit: got %h want ffffff", digit); end
      if (err !== 1'b0) begin errors++; $display("FAIL win_to_set_err: got %b want 0", err); end
   endtask

   task automatic test_invalid();
      press(10'b0000000110);
      checks += 2;
      if (err !== 1'b1) begin errors++; $display("FAIL inv_twohot_err: got %b want 1", err); end
      if (digit !== 24'hFFFFFF) begin errors++; $display("FAIL inv_twohot_idx: got %h want ffffff", digit); end
      press(oh(1));
      checks += 2;
      if (err !== 1'b0) begin errors++; $display("FAIL inv_valid_err: got %b want 0", err); end
      if (digit !== 24'hFF1FFF) begin errors++; $display("FAIL inv_valid_digit: got %h want ff1fff", digit); end
      press(oh(1));
      checks += 2;
      if (err !== 1'b1) begin errors++; $display("FAIL inv_dup_err: got %b want 1", err); end
      if (digit !== 24'hFF1FFF) begin errors++; $display("FAIL inv_dup_digit: got %h want ff1fff", digit); end
      press(10'b0);
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL inv_none_err: got %b want 1", err); end
      press(oh(2)); press(oh(0));
      checks += 2;
      if (err !== 1'b0) begin errors++; $display("FAIL inv_zero_err: got %b want 0", err); end
      if (digit !== 24'hFF120F) begin errors++; $display("FAIL inv_zero_digit: got %h want ff120f", digit); end
      press(oh(9));
      checks++;
      if (led !== 5'b00010) begin errors++; $display("FAIL inv_to_guess: got %b want 00010", led); end
      press(oh(9)); press(oh(9));
      checks += 2;
      if (err !== 1'b1) begin errors++; $display("FAIL inv_guess_dup_err: got %b want 1", err); end
      if (digit !== 24'h0F9FFF) begin errors++; $display("FAIL inv_guess_dup_digit: got %h want 0f9fff", digit); end
   endtask

   task automatic test_lose();
      do_reset();
      enter_word(16'h1234);
      enter_word(16'h5678);
      wait_result();
      checks++;
      if (digit !== 24'h1F0A0B) begin errors++; $display("FAIL lose_show1: got %h want 1f0a0b", digit); end
      press(oh(4));
      enter_word(16'h5678);
      wait_result();
      checks += 2;
      if (led !== 5'b10000) begin errors++; $display("FAIL lose_led: got %b want 10000", led); end
      if (digit !== 24'h2F1234) begin errors++; $display("FAIL lose_digit: got %h want 2f1234", digit); end
      press(oh(2));
      checks += 2;
      if (led !== 5'b00001) begin errors++; $display("FAIL lose_to_set_led: got %b want 00001", led); end
      if (digit !== 24'hFFFFFF) begin errors++; $display("FAIL lose_to_set_digit: got %h want ffffff", digit); end
   endtask

   task automatic test_cmp_ignore();
      logic [7:0]  ab;
      logic [23:0] exp_d;
      do_reset();
      enter_word(16'h4567);
      press(oh(4)); press(oh(6)); press(oh(5));
      @(negedge clk); sw = oh(8); btn = 1'b1;
      @(negedge clk); btn = 1'b0;
      @(negedge clk); sw = oh(9); btn = 1'b1;
      @(negedge clk); btn = 1'b0;
      @(negedge clk); sw = oh(0); btn = 1'b1;
      repeat (10) @(negedge clk);
      ab    = ref_ab(16'h4567, 16'h4658);
      exp_d = {4'd1, 4'hF, ab[7:4], 4'hA, ab[3:0], 4'hB};
      checks += 3;
      if (led !== 5'b00100) begin errors++; $display("FAIL cmp_held_led: got %b want 00100", led); end
      if (digit !== exp_d) begin errors++; $display("FAIL cmp_held_digit: got %h want %h", digit, exp_d); end
      if (err !== 1'b0) begin errors++; $display("FAIL cmp_held_err: got %b want 0", err); end
      btn = 1'b0;
      @(negedge clk); sw = oh(3); btn = 1'b1;
      repeat (6) @(negedge clk);
      checks += 2;
      if (led !== 5'b00010) begin errors++; $display("FAIL held_guess_led: got %b want 00010", led); end
      if (digit !== 24'h1FFFFF) begin errors++; $display("FAIL held_guess_digit: got %h want 1fffff", digit); end
      btn = 1'b0;
      press(oh(3));
      checks++;
      if (digit !== 24'h1F3FFF) begin errors++; $display("FAIL held_then_press: got %h want 1f3fff", digit); end
   endtask

   task automatic test_random();
      logic [15:0] s, g;
      logic [7:0]  ab;
      logic [23:0] exp_d;
      logic [4:0]  exp_l;
      for (int game = 0; game < 8; game++) begin
         do_reset();
         s = rand_word();
         enter_word(s);
         for (int t = 1; t <= int'(MaxTry); t++) begin
            g = ($urandom_range(3, 0) == 0) ? s : rand_word();
            enter_word(g);
            wait_result();
            ab = ref_ab(s, g);
            if (ab[7:4] == 4'd4) begin
               exp_l = 5'b01000; exp_d = {4'(t), 4'hF, 16'h4A0B};
            end else if (t == int'(MaxTry)) begin
               exp_l = 5'b10000; exp_d = {4'(t), 4'hF, s};
            end else begin
               exp_l = 5'b00100; exp_d = {4'(t), 4'hF, ab[7:4], 4'hA, ab[3:0], 4'hB};
            end
            checks += 2;
            if (led !== exp_l) begin errors++; $display("FAIL rand_led: got %b want %b", led, exp_l); end
            if (digit !== exp_d) begin errors++; $display("FAIL rand_digit: got %h want %h", digit, exp_d); end
            press(oh($urandom_range(9, 0)));
            if (exp_l != 5'b00100) break;
         end
      end
   endtask

   initial begin
      test_reset();
      test_show();
      test_win();
      test_invalid();
      test_lose();
      test_cmp_ignore();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
